// File: rtl/aib_link_bringup_ctrl.sv
// AIB link bring-up controller.
// Sequences adapter reset, MAC ready and the AIB handshake (MAC ready,
// transfer enable, RX alignment) on the low-order active channels, with
// per-wait-state timeouts, bounded retries and a sticky failure state.
module aib_link_bringup_ctrl #(
  parameter int NBR_CHNLS      = 24,
  parameter int ACTIVE_CHNLS   = 1,
  parameter int RST_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MAX_RETRY      = 3
) (
  input  logic                 clk_wr,
  input  logic                 rst_wr_n,
  input  logic                 start,
  input  logic                 retrain,
  input  logic [NBR_CHNLS-1:0] fs_mac_rdy,
  input  logic [NBR_CHNLS-1:0] ms_tx_transfer_en,
  input  logic [NBR_CHNLS-1:0] sl_tx_transfer_en,
  input  logic [NBR_CHNLS-1:0] m_rx_align_done,
  output logic [NBR_CHNLS-1:0] ns_adapter_rstn,
  output logic [NBR_CHNLS-1:0] ns_mac_rdy,
  output logic                 link_up,
  output logic                 link_err,
  output logic [2:0]           state,
  output logic [3:0]           retry_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RST_HOLD   = 3'd1,
    ST_WAIT_RDY   = 3'd2,
    ST_WAIT_XFER  = 3'd3,
    ST_WAIT_ALIGN = 3'd4,
    ST_LINK_UP    = 3'd5,
    ST_FAIL       = 3'd6
  } state_e;

  // Active channels are the low-order ACTIVE_CHNLS bits.
  localparam logic [NBR_CHNLS-1:0] ACT_MASK =
    {NBR_CHNLS{1'b1}} >> (NBR_CHNLS - ACTIVE_CHNLS);

  localparam int              RCW          = $clog2(RST_CYCLES + 1);
  localparam logic [RCW-1:0]  RST_LOAD     = RCW'(RST_CYCLES - 1);
  localparam logic [15:0]     TIMEOUT_LOAD = 16'(TIMEOUT_CYCLES);
  localparam logic [4:0]      MAX_RETRY_W  = 5'(MAX_RETRY);

  // Status index order inside the synchronizer bank.
  localparam int IDX_RDY   = 0;
  localparam int IDX_MS    = 1;
  localparam int IDX_SL    = 2;
  localparam int IDX_ALIGN = 3;

  logic [3:0][NBR_CHNLS-1:0] status_raw;
  logic [3:0][NBR_CHNLS-1:0] sync1_q;
  logic [3:0][NBR_CHNLS-1:0] sync2_q;

  state_e         state_q, state_d;
  logic [3:0]     retry_q, retry_d;
  logic [15:0]    timer_q, timer_d;
  logic [RCW-1:0] rst_cnt_q, rst_cnt_d;

  logic rdy_met, xfer_met, align_met, all_met;
  logic fault;
  logic retry_limit;
  logic [3:0] retry_inc;

  assign status_raw[IDX_RDY]   = fs_mac_rdy;
  assign status_raw[IDX_MS]    = ms_tx_transfer_en;
  assign status_raw[IDX_SL]    = sl_tx_transfer_en;
  assign status_raw[IDX_ALIGN] = m_rx_align_done;

  // Two-flop synchronizer for all asynchronous AIB status inputs.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= status_raw;
      sync2_q <= sync1_q;
    end
  end

  // A condition is met when every active bit is high; inactive bits are ignored.
  assign rdy_met   = (sync2_q[IDX_RDY] & ACT_MASK) == ACT_MASK;
  assign xfer_met  = ((sync2_q[IDX_MS] & ACT_MASK) == ACT_MASK) &&
                     ((sync2_q[IDX_SL] & ACT_MASK) == ACT_MASK);
  assign align_met = (sync2_q[IDX_ALIGN] & ACT_MASK) == ACT_MASK;
  assign all_met   = rdy_met && xfer_met && align_met;

  // FSM, timer, reset-hold counter and retry counter registers.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      state_q   <= ST_IDLE;
      retry_q   <= '0;
      timer_q   <= '0;
      rst_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      retry_q   <= retry_d;
      timer_q   <= timer_d;
      rst_cnt_q <= rst_cnt_d;
    end
  end

  // Next-state logic: handshake progress, timeouts, link loss and retry policy.
  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    timer_d     = timer_q;
    rst_cnt_d   = rst_cnt_q;
    fault       = 1'b0;
    retry_inc   = (retry_q == 4'hF) ? 4'hF : retry_q + 4'd1;
    retry_limit = ({1'b0, retry_q} + 5'd1) >= MAX_RETRY_W;

    case (state_q)
      ST_IDLE, ST_FAIL: begin
        if (start) begin
          state_d   = ST_RST_HOLD;
          retry_d   = '0;
          rst_cnt_d = RST_LOAD;
          timer_d   = '0;
        end
      end
      ST_RST_HOLD: begin
        if (rst_cnt_q == '0) begin
          state_d = ST_WAIT_RDY;
          timer_d = TIMEOUT_LOAD;
        end else begin
          rst_cnt_d = rst_cnt_q - 1'b1;
        end
      end
      ST_WAIT_RDY: begin
        if (rdy_met) begin
          state_d = ST_WAIT_XFER;
          timer_d = TIMEOUT_LOAD;
        end else if (timer_q == '0) begin
          fault = 1'b1;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      ST_WAIT_XFER: begin
        if (xfer_met) begin
          state_d = ST_WAIT_ALIGN;
          timer_d = TIMEOUT_LOAD;
        end else if (timer_q == '0) begin
          fault = 1'b1;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      ST_WAIT_ALIGN: begin
        if (align_met) begin
          state_d = ST_LINK_UP;
          timer_d = '0;
        end else if (timer_q == '0) begin
          fault = 1'b1;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      ST_LINK_UP: begin
        // Retrain wins over a coincident link loss.
        if (retrain) begin
          state_d   = ST_RST_HOLD;
          retry_d   = '0;
          rst_cnt_d = RST_LOAD;
        end else if (!all_met) begin
          fault = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Timeout or link loss: count the attempt, then retry or give up.
    if (fault) begin
      retry_d   = retry_inc;
      rst_cnt_d = RST_LOAD;
      timer_d   = '0;
      state_d   = retry_limit ? ST_FAIL : ST_RST_HOLD;
    end
  end

  // Moore outputs decoded from registered state only.
  always_comb begin
    ns_adapter_rstn = '0;
    ns_mac_rdy      = '0;
    if (state_q inside {ST_WAIT_RDY, ST_WAIT_XFER, ST_WAIT_ALIGN, ST_LINK_UP}) begin
      ns_adapter_rstn = ACT_MASK;
      ns_mac_rdy      = ACT_MASK;
    end
  end

  assign link_up   = (state_q == ST_LINK_UP);
  assign link_err  = (state_q == ST_FAIL);
  assign state     = state_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_aib_link_bringup_ctrl.sv
// Bench for aib_link_bringup_ctrl: directed scenarios with literal expectations
// plus a randomized phase, all compared every cycle against a behavioural model.
module tb_aib_link_bringup_ctrl;

  localparam int NBR  = 24;
  localparam int ACTN = 2;
  localparam int RSTC = 4;
  localparam int TMO  = 20;
  localparam int MAXR = 2;
  localparam logic [NBR-1:0] ACT = 24'h000003;

  logic            clk_wr   = 1'b0;
  logic            rst_wr_n = 1'b1;
  logic            start    = 1'b0;
  logic            retrain  = 1'b0;
  logic [NBR-1:0]  fs_mac_rdy = '0;
  logic [NBR-1:0]  ms_tx_transfer_en = '0;
  logic [NBR-1:0]  sl_tx_transfer_en = '0;
  logic [NBR-1:0]  m_rx_align_done = '0;
  logic [NBR-1:0]  ns_adapter_rstn;
  logic [NBR-1:0]  ns_mac_rdy;
  logic            link_up;
  logic            link_err;
  logic [2:0]      state;
  logic [3:0]      retry_cnt;

  // Active-channel bits requested by the scenario; upper bits are random noise.
  logic [1:0] fs_act = '0, ms_act = '0, sl_act = '0, al_act = '0;

  int tests = 0;
  int fails = 0;

  aib_link_bringup_ctrl #(
    .NBR_CHNLS(NBR), .ACTIVE_CHNLS(ACTN), .RST_CYCLES(RSTC),
    .TIMEOUT_CYCLES(TMO), .MAX_RETRY(MAXR)
  ) dut (
    .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .start(start), .retrain(retrain),
    .fs_mac_rdy(fs_mac_rdy), .ms_tx_transfer_en(ms_tx_transfer_en),
    .sl_tx_transfer_en(sl_tx_transfer_en), .m_rx_align_done(m_rx_align_done),
    .ns_adapter_rstn(ns_adapter_rstn), .ns_mac_rdy(ns_mac_rdy),
    .link_up(link_up), .link_err(link_err), .state(state), .retry_cnt(retry_cnt)
  );

  always #5 clk_wr = ~clk_wr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // State is tracked as the numeric state code plus the number of cycles
  // already spent in it; synchronized status is the input seen two edges ago.
  int m_state = 0;
  int m_dwell = 0;
  int m_retry = 0;
  logic [NBR-1:0] h1 [4] = '{default: '0};
  logic [NBR-1:0] h2 [4] = '{default: '0};

  always @(posedge clk_wr or negedge rst_wr_n) begin : model
    int ns;
    int nr;
    bit fault;
    bit met [4];
    if (!rst_wr_n) begin
      m_state <= 0;
      m_dwell <= 0;
      m_retry <= 0;
      for (int i = 0; i < 4; i++) begin
        h1[i] <= '0;
        h2[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) met[i] = ((h2[i] & ACT) == ACT);
      ns = m_state;
      nr = m_retry;
      fault = 1'b0;
      case (m_state)
        0, 6: if (start) begin ns = 1; nr = 0; end
        1: if (m_dwell == RSTC - 1) ns = 2;
        2: if (met[0]) ns = 3; else if (m_dwell == TMO) fault = 1'b1;
        3: if (met[1] && met[2]) ns = 4; else if (m_dwell == TMO) fault = 1'b1;
        4: if (met[3]) ns = 5; else if (m_dwell == TMO) fault = 1'b1;
        5: if (retrain) begin ns = 1; nr = 0; end
           else if (!(met[0] && met[1] && met[2] && met[3])) fault = 1'b1;
        default: ns = 0;
      endcase
      if (fault) begin
        nr = (m_retry + 1 > 15) ? 15 : m_retry + 1;
        ns = (m_retry + 1 < MAXR) ? 1 : 6;
      end
      m_dwell <= (ns != m_state) ? 0 : ((m_dwell < 100000) ? m_dwell + 1 : m_dwell);
      m_state <= ns;
      m_retry <= nr;
      for (int i = 0; i < 4; i++) h2[i] <= h1[i];
      h1[0] <= fs_mac_rdy;
      h1[1] <= ms_tx_transfer_en;
      h1[2] <= sl_tx_transfer_en;
      h1[3] <= m_rx_align_done;
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk_wr) begin
    logic [NBR-1:0] exp_en;
    exp_en = (m_state >= 2 && m_state <= 5) ? ACT : '0;
    check("cyc_state",     32'(state),           32'(m_state));
    check("cyc_retry_cnt", 32'(retry_cnt),       32'(m_retry));
    check("cyc_link_up",   32'(link_up),         32'(m_state == 5));
    check("cyc_link_err",  32'(link_err),        32'(m_state == 6));
    check("cyc_adapt_rst", 32'(ns_adapter_rstn), 32'(exp_en));
    check("cyc_mac_rdy",   32'(ns_mac_rdy),      32'(exp_en));
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_status();
    fs_mac_rdy        = {22'($urandom), fs_act};
    ms_tx_transfer_en = {22'($urandom), ms_act};
    sl_tx_transfer_en = {22'($urandom), sl_act};
    m_rx_align_done   = {22'($urandom), al_act};
  endtask

  task automatic tick();
    drive_status();
    @(posedge clk_wr);
    #1;
  endtask

  task automatic wait_state(input int tgt, input int budget, input string name);
    int n;
    n = 0;
    while (int'(state) != tgt && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(state), 32'(tgt));
  endtask

  task automatic count_dwell(input int st, output int cnt);
    cnt = 0;
    while (int'(state) == st && cnt < 100) begin
      tick();
      cnt++;
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n;
    int cnt;

    #1 rst_wr_n = 1'b0;
    repeat (3) tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_flags", 32'({link_up, link_err, retry_cnt}), 32'd0);
    check("rst_adapt_rst", 32'(ns_adapter_rstn), 32'd0);
    rst_wr_n = 1'b1;
    fs_act = 2'b11; ms_act = 2'b11; sl_act = 2'b11; al_act = 2'b11;
    repeat (5) tick();
    check("idle_until_start", 32'(state), 32'd0);

    // Happy path: start sampled at cycle 0.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("hp_rst_hold_c1", 32'(state), 32'd1);
    for (int c = 2; c <= 4; c++) begin
      tick();
      check("hp_rst_hold", 32'(state), 32'd1);
      check("hp_adapt_rst_low", 32'(ns_adapter_rstn), 32'd0);
    end
    tick();
    check("hp_wait_rdy_c5", 32'(state), 32'd2);
    check("hp_adapt_rst_c5", 32'(ns_adapter_rstn), 32'h000003);
    n = 0;
    while (!link_up && n < 9) begin
      tick();
      n++;
    end
    check("hp_link_up", 32'(link_up), 32'd1);

    // Start is ignored while the link is up.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_ignored_link_up", 32'(state), 32'd5);

    // One-cycle loss of m_rx_align_done[0].
    al_act = 2'b10;
    tick();
    al_act = 2'b11;
    n = 0;
    while (int'(state) != 1 && n < 3) begin
      tick();
      n++;
    end
    check("loss_rst_hold", 32'(state), 32'd1);
    check("loss_retry_cnt", 32'(retry_cnt), 32'd1);
    check("loss_link_down", 32'(link_up), 32'd0);
    wait_state(5, 40, "relink");

    // Retrain in the same cycle the loss becomes visible.
    al_act = 2'b10;
    tick();
    al_act = 2'b11;
    tick();
    retrain = 1'b1;
    tick();
    retrain = 1'b0;
    check("retrain_rst_hold", 32'(state), 32'd1);
    check("retrain_retry_clr", 32'(retry_cnt), 32'd0);

    // Park in WAIT_XFER, then assert reset mid-cycle.
    ms_act = 2'b01;
    wait_state(3, 20, "reach_wait_xfer");
    tick();
    tick();
    check("hold_wait_xfer", 32'(state), 32'd3);
    #3 rst_wr_n = 1'b0;
    #1;
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_adapt", 32'(ns_adapter_rstn), 32'd0);
    check("async_rst_mac", 32'(ns_mac_rdy), 32'd0);
    check("async_rst_flags", 32'({link_up, link_err, retry_cnt}), 32'd0);
    ms_act = 2'b11;
    tick();
    tick();
    rst_wr_n = 1'b1;
    repeat (3) tick();
    check("idle_after_rst", 32'(state), 32'd0);

    // Persistent fs_mac_rdy[1] low: two timeouts, then FAIL.
    fs_act = 2'b01;
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_state(2, 10, "tmo_enter1");
    count_dwell(2, cnt);
    check("tmo1_dwell", 32'(cnt), 32'd21);
    check("tmo1_state", 32'(state), 32'd1);
    check("tmo1_retry", 32'(retry_cnt), 32'd1);
    wait_state(2, 10, "tmo_enter2");
    count_dwell(2, cnt);
    check("tmo2_dwell", 32'(cnt), 32'd21);
    check("tmo2_state", 32'(state), 32'd6);
    check("tmo2_retry", 32'(retry_cnt), 32'd2);
    check("tmo2_link_err", 32'(link_err), 32'd1);
    retrain = 1'b1;
    tick();
    retrain = 1'b0;
    check("retrain_ignored_fail", 32'(state), 32'd6);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_state", 32'(state), 32'd1);
    check("restart_link_err", 32'(link_err), 32'd0);
    check("restart_retry", 32'(retry_cnt), 32'd0);
    fs_act = 2'b11;

    // Randomized phase, checked every cycle against the model.
    for (int i = 0; i < 2000; i++) begin
      start   = ($urandom_range(0, 15) == 0);
      retrain = ($urandom_range(0, 31) == 0);
      fs_act  = {($urandom_range(0, 39) != 0), ($urandom_range(0, 39) != 0)};
      ms_act  = {($urandom_range(0, 39) != 0), ($urandom_range(0, 39) != 0)};
      sl_act  = {($urandom_range(0, 39) != 0), ($urandom_range(0, 39) != 0)};
      al_act  = {($urandom_range(0, 39) != 0), ($urandom_range(0, 39) != 0)};
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_wr_n = 1'b0;
        tick();
        rst_wr_n = 1'b1;
      end
      tick();
    end
    start = 1'b0;
    retrain = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
